branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_pkg.sv | 17 +
 rtl/pred_fifo.sv | 66 ++++++
 rtl/branch_resolver.sv | 134 +++++++++++++
 tb/tb_branch_resolver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch resolver: FSM state encoding,
// default sizing, and the direction-compare helper.
package branch_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [0:0] {
        TRACK = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic logic is_mispredict(input logic predicted, input logic actual);
        return predicted ^ actual;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// DEPTH x 1-bit circular buffer holding predicted directions, oldest at the
// read pointer. Pointers carry one extra bit so full and empty are distinguishable.
module pred_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          data_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic          data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [DEPTH-1:0] mem_q;

    // Next pointer values; clear overrides any push or pop in the same cycle.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clear_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) begin
                wr_d = wr_q + PTR_ONE;
            end else begin
                wr_d = wr_q;
            end
            if (pop_i) begin
                rd_d = rd_q + PTR_ONE;
            end else begin
                rd_d = rd_q;
            end
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push_i && !clear_i) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign count_o = wr_q - rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);

endmodule

// File: rtl/branch_resolver.sv
// Tracks outstanding branch predictions in order, compares them against
// resolved outcomes, and emits predictor updates, flushes and statistics.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic             flush,
    output logic [AW:0]      occupancy,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic             underflow_err
);

    state_e           state_q, state_d;
    logic             upd_valid_q, upd_valid_d;
    logic             upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             underflow_q, underflow_d;

    logic             head_s;
    logic [AW:0]      count_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             mis_s;
    logic             push_s;
    logic             ready_s;
    logic             flush_s;

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push_s),
        .data_i  (pred_taken),
        .pop_i   (pop_s),
        .clear_i (mis_s),
        .data_o  (head_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // FSM outputs: readiness reflects fullness before any same-cycle pop.
    always_comb begin
        ready_s = 1'b0;
        flush_s = 1'b0;
        case (state_q)
            TRACK: begin
                ready_s = !full_s;
                flush_s = 1'b0;
            end
            FLUSH: begin
                ready_s = 1'b0;
                flush_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
                flush_s = 1'b0;
            end
        endcase
    end

    // A mispredicting pop empties the buffer and swallows any concurrent push.
    always_comb begin
        pop_s  = resolve_valid && (state_q == TRACK) && !empty_s;
        mis_s  = pop_s && is_mispredict(head_s, resolve_taken);
        push_s = pred_valid && ready_s && !mis_s;
    end

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACK: begin
                if (mis_s) begin
                    state_d = FLUSH;
                end else begin
                    state_d = TRACK;
                end
            end
            FLUSH:   state_d = TRACK;
            default: state_d = TRACK;
        endcase
    end

    // Update pulse, saturating statistics and sticky underflow next-state.
    always_comb begin
        upd_valid_d = pop_s;
        upd_taken_d = resolve_taken;
        if (mis_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
        underflow_d = underflow_q | (resolve_valid & ~pop_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TRACK;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            upd_valid_q <= upd_valid_d;
            upd_taken_q <= upd_taken_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign pred_ready     = ready_s;
    assign flush          = flush_s;
    assign upd_valid      = upd_valid_q;
    assign upd_taken      = upd_taken_q;
    assign occupancy      = count_s;
    assign mispredict_cnt = cnt_q;
    assign underflow_err  = underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (DEPTH=4, CNT_W=2) with a reference
// queue model and a scoreboard of expected update pulses.
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             upd_valid;
    logic             upd_taken;
    logic             flush;
    logic [2:0]       occupancy;
    logic [CNT_W-1:0] mispredict_cnt;
    logic             underflow_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic m_q[$];
    logic m_flush;
    int   m_cnt;
    logic m_under;
    typedef struct { logic taken; logic fl; } upd_t;
    upd_t sb[$];

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_ready     (pred_ready),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .upd_valid      (upd_valid),
        .upd_taken      (upd_taken),
        .flush          (flush),
        .occupancy      (occupancy),
        .mispredict_cnt (mispredict_cnt),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_flush = 1'b0;
        m_cnt   = 0;
        m_under = 1'b0;
    endtask

    // One clock: drive, check readiness, advance model, check outputs after the edge.
    task automatic cyc(input string tag, input logic pv, input logic pt,
                       input logic rv, input logic rt);
        logic ready, pop, mis, push;
        upd_t u;
        pred_valid    = pv;
        pred_taken    = pt;
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
        ready = !m_flush && (m_q.size() < DEPTH);
        pop   = rv && !m_flush && (m_q.size() > 0);
        mis   = pop && (m_q[0] != rt);
        push  = pv && ready && !mis;
        chk({tag, ".pred_ready"}, int'(pred_ready), int'(ready));
        if (rv && !pop) m_under = 1'b1;
        if (pop) begin
            u.taken = rt;
            u.fl    = mis;
            sb.push_back(u);
            void'(m_q.pop_front());
        end
        if (mis) begin
            m_q.delete();
            m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end else if (push) begin
            m_q.push_back(pt);
        end
        m_flush = mis;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            u = sb.pop_front();
            chk({tag, ".upd_valid"}, int'(upd_valid), 1);
            chk({tag, ".upd_taken"}, int'(upd_taken), int'(u.taken));
            chk({tag, ".flush"}, int'(flush), int'(u.fl));
        end else begin
            chk({tag, ".upd_valid"}, int'(upd_valid), 0);
            chk({tag, ".flush"}, int'(flush), 0);
        end
        chk({tag, ".occupancy"}, int'(occupancy), m_q.size());
        chk({tag, ".mispredict_cnt"}, int'(mispredict_cnt), m_cnt);
        chk({tag, ".underflow_err"}, int'(underflow_err), int'(m_under));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".occupancy"}, int'(occupancy), 0);
        chk({tag, ".upd_valid"}, int'(upd_valid), 0);
        chk({tag, ".upd_taken"}, int'(upd_taken), 0);
        chk({tag, ".flush"}, int'(flush), 0);
        chk({tag, ".mispredict_cnt"}, int'(mispredict_cnt), 0);
        chk({tag, ".underflow_err"}, int'(underflow_err), 0);
    endtask

    initial begin
        pred_valid    = 1'b0;
        pred_taken    = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("post_reset.pred_ready", int'(pred_ready), 1);

        // In-order correct flow
        cyc("inorder.push0", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("inorder.push1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("inorder.push2", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("inorder.occ3", int'(occupancy), 3);
        cyc("inorder.res0", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("inorder.res1", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("inorder.res2", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("inorder.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("inorder.cnt", int'(mispredict_cnt), 0);

        // Mispredict flush
        cyc("misp.push0", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("misp.push1", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("misp.push2", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("misp.res", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("misp.flush", int'(flush), 1);
        chk("misp.ready_in_flush", int'(pred_ready), 0);
        cyc("misp.after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("misp.cnt", int'(mispredict_cnt), 1);
        chk("misp.ready_after", int'(pred_ready), 1);

        // Full buffer with simultaneous pop and offered push
        cyc("full.push0", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("full.push1", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("full.push2", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("full.push3", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full.occ4", int'(occupancy), 4);
        chk("full.ready0", int'(pred_ready), 0);
        cyc("full.pop_nopush", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("full.occ3", int'(occupancy), 3);
        cyc("full.push_next", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("full.occ_back4", int'(occupancy), 4);
        cyc("full.drain0", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("full.drain1", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("full.drain2", 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("full.drain3", 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("full.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Push discarded by a same-cycle mispredict
        cyc("discard.push", 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("discard.misp_push", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("discard.occ0", int'(occupancy), 0);
        cyc("discard.after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("discard.occ_after", int'(occupancy), 0);

        // Underflow: resolve with nothing outstanding
        cyc("under.res", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("under.sticky_set", int'(underflow_err), 1);
        cyc("under.idle0", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("under.idle1", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("under.sticky_hold", int'(underflow_err), 1);

        // Counter saturation: five further mispredicts
        for (int i = 0; i < 5; i++) begin
            cyc("sat.push", 1'b1, 1'b0, 1'b0, 1'b0);
            cyc("sat.misp", 1'b0, 1'b0, 1'b1, 1'b1);
            if (i < 4) cyc("sat.flush_res", 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("sat.cnt", int'(mispredict_cnt), CMAX);
        chk("sat.flush_live", int'(flush), 1);

        // Asynchronous reset mid-cycle while a flush/update pulse is live
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("async_reset.ready", int'(pred_ready), 1);
        cyc("post.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
